// File: rtl/spi_word_fifo.sv
// SPI symbol packer: assembles BYTES_PER_WORD payload bytes into mode-tagged words
// and buffers them in a DEPTH-entry first-word-fall-through FIFO with valid/ready output.
module spi_word_fifo #(
    parameter int BYTES_PER_WORD = 2,
    parameter int DEPTH          = 160,
    parameter int AW             = $clog2(DEPTH)
) (
    input  logic                        CLK,
    input  logic                        Reset_n,
    input  logic [8:0]                  i_Data,
    input  logic                        i_SPI_valid,
    output logic                        o_SPI_ready,
    input  logic                        i_Flush,
    output logic [8*BYTES_PER_WORD-1:0] o_Data_RAM,
    output logic                        o_Mode,
    output logic                        o_RAM_valid,
    input  logic                        i_RAM_ready,
    output logic [AW:0]                 o_Count,
    output logic                        o_Frame_err
);

    localparam int              W       = 8 * BYTES_PER_WORD;
    localparam int              BW      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BW-1:0]   LAST    = BW'(BYTES_PER_WORD - 1);
    localparam logic [AW:0]     FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_MAX = AW'(DEPTH - 1);

    logic [BW-1:0] bcnt;
    logic [W-1:0]  sreg;
    logic          cap_mode;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [W:0]    mem [DEPTH];

    logic          at_last;
    logic          accept;
    logic          mismatch;
    logic          push;
    logic          pop;
    logic [W-1:0]  word_in;

    always_comb begin
        at_last     = (bcnt == LAST);
        o_SPI_ready = !i_Flush && (!at_last || (o_Count < FULL));
        accept      = i_SPI_valid && o_SPI_ready;
        mismatch    = accept && (bcnt != '0) && (i_Data[8] != cap_mode);
        push        = accept && at_last && !mismatch;
        o_RAM_valid = (o_Count != '0);
        pop         = o_RAM_valid && i_RAM_ready;
        // Older bytes shift toward the MSBs; anything beyond W bits falls off the top.
        word_in     = (sreg << 8) | W'(i_Data[7:0]);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            bcnt        <= '0;
            sreg        <= '0;
            cap_mode    <= 1'b0;
            o_Frame_err <= 1'b0;
        end else begin
            o_Frame_err <= mismatch;
            if (i_Flush) begin
                bcnt <= '0;
            end else if (accept) begin
                if (mismatch) begin
                    // Mode changed mid-word: the offending byte becomes the first byte of a new word.
                    bcnt     <= BW'(1);
                    sreg     <= W'(i_Data[7:0]);
                    cap_mode <= i_Data[8];
                end else if (at_last) begin
                    bcnt <= '0;
                    sreg <= word_in;
                end else begin
                    bcnt <= bcnt + BW'(1);
                    sreg <= word_in;
                    if (bcnt == '0) cap_mode <= i_Data[8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {i_Data[8], word_in};
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + AW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   o_Count <= o_Count + (AW + 1)'(1);
                2'b01:   o_Count <= o_Count - (AW + 1)'(1);
                default: o_Count <= o_Count;
            endcase
        end
    end

    always_comb begin
        o_Mode     = o_RAM_valid ? mem[rd_ptr][W]     : 1'b0;
        o_Data_RAM = o_RAM_valid ? mem[rd_ptr][W-1:0] : '0;
    end

endmodule

// File: tb/tb_spi_word_fifo.sv
// Scoreboard bench for spi_word_fifo: a BPW=2/DEPTH=4 instance and a BPW=3/DEPTH=4 instance.
module tb_spi_word_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [8:0]  d2, d3;
    logic        v2, v3, f2, f3, rr2, rr3;
    logic        sr2, sr3, m2, m3, rv2, rv3, fe2, fe3;
    logic [15:0] rd2;
    logic [23:0] rd3;
    logic [2:0]  cnt2, cnt3;

    int checks   = 0;
    int failures = 0;
    logic [16:0] q2[$];
    logic        fin2 = 1'b0;

    spi_word_fifo #(.BYTES_PER_WORD(2), .DEPTH(4)) dut2 (
        .CLK(clk), .Reset_n(rst_n), .i_Data(d2), .i_SPI_valid(v2), .o_SPI_ready(sr2),
        .i_Flush(f2), .o_Data_RAM(rd2), .o_Mode(m2), .o_RAM_valid(rv2),
        .i_RAM_ready(rr2), .o_Count(cnt2), .o_Frame_err(fe2)
    );

    spi_word_fifo #(.BYTES_PER_WORD(3), .DEPTH(4)) dut3 (
        .CLK(clk), .Reset_n(rst_n), .i_Data(d3), .i_SPI_valid(v3), .o_SPI_ready(sr3),
        .i_Flush(f3), .o_Data_RAM(rd3), .o_Mode(m3), .o_RAM_valid(rv3),
        .i_RAM_ready(rr3), .o_Count(cnt3), .o_Frame_err(fe3)
    );

    task automatic send2(input logic [8:0] d);
        int n;
        n  = 0;
        d2 = d;
        v2 = 1'b1;
        forever begin
            @(negedge clk);
            if (sr2) break;
            n++;
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL send2_timeout ready=%b want 1", sr2);
                break;
            end
        end
        @(posedge clk); #1;
        v2 = 1'b0;
    endtask

    task automatic send3(input logic [8:0] d);
        int n;
        n  = 0;
        d3 = d;
        v3 = 1'b1;
        forever begin
            @(negedge clk);
            if (sr3) break;
            n++;
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL send3_timeout ready=%b want 1", sr3);
                break;
            end
        end
        @(posedge clk); #1;
        v3 = 1'b0;
    endtask

    task automatic pop2(input string tag);
        logic [16:0] exp;
        int n;
        n = 0;
        @(negedge clk);
        while (!rv2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        exp = (q2.size() > 0) ? q2.pop_front() : 17'h1ffff;
        checks++;
        if ({m2, rd2} !== exp) begin
            failures++;
            $display("FAIL %s head got %h want %h", tag, {m2, rd2}, exp);
        end
        rr2 = 1'b1;
        @(posedge clk); #1;
        rr2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d2 = 9'h1AB; v2 = 1'b1; f2 = 1'b0; rr2 = 1'b0;
        d3 = 9'h0AA; v3 = 1'b1; f3 = 1'b0; rr3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rv2 !== 1'b0)   begin failures++; $display("FAIL rst_valid got %b want 0", rv2); end
        checks++; if (rd2 !== 16'h0)  begin failures++; $display("FAIL rst_data got %h want 0", rd2); end
        checks++; if (m2 !== 1'b0)    begin failures++; $display("FAIL rst_mode got %b want 0", m2); end
        checks++; if (fe2 !== 1'b0)   begin failures++; $display("FAIL rst_frame_err got %b want 0", fe2); end
        checks++; if (cnt2 !== 3'd0)  begin failures++; $display("FAIL rst_count got %0d want 0", cnt2); end
        checks++; if (sr2 !== 1'b1)   begin failures++; $display("FAIL rst_ready got %b want 1", sr2); end
        @(posedge clk); #1;
        v2 = 1'b0; v3 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cnt2 !== 3'd0 || cnt3 !== 3'd0) begin
            failures++; $display("FAIL rst_no_accept count2=%0d count3=%0d want 0", cnt2, cnt3);
        end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        send2(9'h1AB);
        send2(9'h1CD);
        q2.push_back({1'b1, 16'hABCD});
        @(negedge clk);
        checks++; if (rv2 !== 1'b1)      begin failures++; $display("FAIL basic_valid got %b want 1", rv2); end
        checks++; if (rd2 !== 16'hABCD)  begin failures++; $display("FAIL basic_data got %h want abcd", rd2); end
        checks++; if (m2 !== 1'b1)       begin failures++; $display("FAIL basic_mode got %b want 1", m2); end
        checks++; if (cnt2 !== 3'd1)     begin failures++; $display("FAIL basic_count got %0d want 1", cnt2); end
        pop2("basic_pop");
        @(negedge clk);
        checks++; if (rv2 !== 1'b0 || rd2 !== 16'h0 || m2 !== 1'b0) begin
            failures++; $display("FAIL basic_empty valid=%b data=%h mode=%b want 0/0/0", rv2, rd2, m2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        logic [7:0]  b;
        logic [16:0] exp;
        rr2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'h10 + 8'(i);
            send2({1'b0, b});
            q2.push_back({1'b0, b, b + 8'h10});
            send2({1'b0, b + 8'h10});
        end
        @(negedge clk);
        checks++; if (cnt2 !== 3'd4) begin failures++; $display("FAIL full_count got %0d want 4", cnt2); end
        @(posedge clk); #1;
        send2(9'h011);
        d2 = 9'h022; v2 = 1'b1;
        @(negedge clk);
        checks++; if (sr2 !== 1'b0) begin failures++; $display("FAIL full_stall got %b want 0", sr2); end
        repeat (2) @(negedge clk);
        checks++; if (sr2 !== 1'b0 || cnt2 !== 3'd4) begin
            failures++; $display("FAIL full_hold ready=%b count=%0d want 0/4", sr2, cnt2);
        end
        exp = q2.pop_front();
        checks++; if ({m2, rd2} !== exp) begin failures++; $display("FAIL full_head got %h want %h", {m2, rd2}, exp); end
        q2.push_back({1'b0, 16'h1122});
        rr2 = 1'b1;
        @(posedge clk); #1;
        rr2 = 1'b0;
        @(negedge clk);
        checks++; if (sr2 !== 1'b1) begin failures++; $display("FAIL full_resume got %b want 1", sr2); end
        @(posedge clk); #1;
        v2 = 1'b0;
        @(negedge clk);
        checks++; if (cnt2 !== 3'd4) begin failures++; $display("FAIL full_refill got %0d want 4", cnt2); end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) pop2("full_drain");
        @(negedge clk);
        checks++; if (cnt2 !== 3'd0) begin failures++; $display("FAIL full_drained got %0d want 0", cnt2); end
        @(posedge clk); #1;
    endtask

    task automatic test_mode_change();
        send2(9'h012);
        send2(9'h134);
        @(negedge clk);
        checks++; if (fe2 !== 1'b1) begin failures++; $display("FAIL frame_err_pulse got %b want 1", fe2); end
        checks++; if (cnt2 !== 3'd0) begin failures++; $display("FAIL frame_no_push got %0d want 0", cnt2); end
        @(negedge clk);
        checks++; if (fe2 !== 1'b0) begin failures++; $display("FAIL frame_err_width got %b want 0", fe2); end
        @(posedge clk); #1;
        send2(9'h156);
        q2.push_back({1'b1, 16'h3456});
        @(negedge clk);
        checks++; if (fe2 !== 1'b0) begin failures++; $display("FAIL frame_err_spurious got %b want 0", fe2); end
        pop2("mode_word");
    endtask

    task automatic test_back_to_back();
        int exp_cnt;
        int popped;
        exp_cnt = 0;
        popped  = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    q2.push_back({1'b0, 16'(i)});
                    send2(9'h000);
                    fin2 = 1'b1;
                    send2({1'b0, 8'(i)});
                    fin2 = 1'b0;
                end
            end
            begin
                int  cyc;
                logic pu, po;
                logic [16:0] exp;
                cyc = 0;
                while (popped < 10 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    checks++;
                    if (int'(cnt2) !== exp_cnt) begin
                        failures++; $display("FAIL stream_count got %0d want %0d", cnt2, exp_cnt);
                    end
                    checks++;
                    if (cnt2 > 3'd4) begin failures++; $display("FAIL stream_count_max got %0d want <=4", cnt2); end
                    pu = v2 && sr2 && fin2;
                    po = rv2 && rr2;
                    if (po) begin
                        exp = (q2.size() > 0) ? q2.pop_front() : 17'h1ffff;
                        checks++;
                        if ({m2, rd2} !== exp) begin
                            failures++; $display("FAIL stream_order got %h want %h", {m2, rd2}, exp);
                        end
                        popped++;
                    end
                    exp_cnt = exp_cnt + int'(pu) - int'(po);
                    @(posedge clk); #1;
                    rr2 = 1'($urandom_range(0, 1));
                end
                rr2 = 1'b0;
                if (popped < 10) begin
                    checks++; failures++;
                    $display("FAIL stream_timeout popped=%0d want 10", popped);
                end
            end
        join
    endtask

    task automatic test_bpw3();
        @(posedge clk); #1;
        send3(9'h001);
        send3(9'h002);
        f3 = 1'b1;
        @(negedge clk);
        checks++; if (sr3 !== 1'b0) begin failures++; $display("FAIL flush_ready got %b want 0", sr3); end
        @(posedge clk); #1;
        f3 = 1'b0;
        send3(9'h0AA);
        send3(9'h0BB);
        send3(9'h0CC);
        @(negedge clk);
        checks++; if (rv3 !== 1'b1 || rd3 !== 24'hAABBCC || m3 !== 1'b0 || cnt3 !== 3'd1) begin
            failures++; $display("FAIL flush_word got v=%b d=%h m=%b c=%0d want 1/aabbcc/0/1", rv3, rd3, m3, cnt3);
        end
        @(posedge clk); #1;
        for (int i = 1; i < 7; i++) send3({1'b0, 8'(i)});
        send3(9'h007);
        @(negedge clk);
        checks++; if (cnt3 !== 3'd3) begin failures++; $display("FAIL bpw3_count got %0d want 3", cnt3); end
        rst_n = 1'b0;
        #1;
        checks++; if (cnt3 !== 3'd0 || rv3 !== 1'b0 || rd3 !== 24'h0 || fe3 !== 1'b0) begin
            failures++; $display("FAIL async_reset got c=%0d v=%b d=%h fe=%b want 0/0/0/0", cnt3, rv3, rd3, fe3);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send3(9'h0DD);
        send3(9'h0EE);
        send3(9'h0FF);
        @(negedge clk);
        checks++; if (rd3 !== 24'hDDEEFF || cnt3 !== 3'd1) begin
            failures++; $display("FAIL post_reset_word got d=%h c=%0d want ddeeff/1", rd3, cnt3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_mode_change();
        test_back_to_back();
        test_bpw3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
